sfx_arbiter: RTL and testbench
==============================

SFX_ARBITER -- requirements
Module: sfx_arbiter

Parameters
REQ-001 SHALL have parameter AMP, default 16'sd8000: tone amplitude, two's complement.
REQ-002 SHALL have parameters HP0/HP1/HP2, defaults 24/48/120: half-period of effect 0/1/2, in samples, each >= 1.
REQ-003 SHALL have parameters DUR0/DUR1/DUR2, defaults 4800/7200/24000: length of effect 0/1/2, in samples, each >= 1.

Interface
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset_n  in  1  synchronous reset, active-low.
REQ-006 req  in  3  one-cycle effect request pulses: bit0 score, bit1 jump, bit2 collision.
REQ-007 mute  in  1  forces output samples to 0 while the sequencing continues unchanged.
REQ-008 sample_data  out  16  signed sample to the audio-core DAC FIFO; the wrapper drives it to both left and right channels.
REQ-009 sample_valid  out  1  sample_data is valid.
REQ-010 sample_ready  in  1  audio FIFO accepts a sample; transfer = sample_valid & sample_ready.
REQ-011 busy  out  1  high in state PLAY.
REQ-012 active_id  out  2  index of the effect playing; 0 when IDLE.

Function
REQ-013 SHALL keep a pending[2:0] register: bit i is set in the cycle after req[i]=1 and cleared in the cycle effect i is started.
REQ-014 A req[i] that coincides with the start of effect i SHALL leave pending[i] set.
REQ-015 Priority SHALL be fixed: collision (2) > jump (1) > score (0).
REQ-016 States SHALL be IDLE and PLAY.
REQ-017 IDLE with pending != 0: next cycle SHALL be PLAY, with id = highest pending bit, phase_cnt=0, dur_cnt=0, polarity=+.
REQ-018 PLAY with a pending bit strictly higher than id: preemption SHALL occur only on a transfer cycle and restart as in REQ-017 with the higher id.
REQ-019 A pending bit equal to or lower than id SHALL wait until the current effect ends.
REQ-020 Output register, IDLE: after reset, sample_valid SHALL be 1 continuously; sample_data SHALL load 0 on each transfer.
REQ-021 Output register, PLAY: sample_data SHALL load +AMP (polarity +) or -AMP (polarity -) on each transfer, or 0 if mute.
REQ-022 sample_data SHALL hold stable while sample_valid & !sample_ready.
REQ-023 Counters SHALL advance only on transfer cycles in PLAY, once per tone sample loaded.
REQ-024 phase_cnt (16 bit): when phase_cnt == HP[id]-1 it SHALL wrap to 0 and toggle polarity; otherwise it increments.
REQ-025 dur_cnt (24 bit): when dur_cnt == DUR[id]-1 the effect SHALL end.
REQ-026 At effect end, if pending != 0 the highest pending effect SHALL start in the next cycle; otherwise the block returns to IDLE.
REQ-027 Result: each uninterrupted effect SHALL load exactly DUR[id] tone samples, alternating HP[id] at +AMP and HP[id] at -AMP, starting positive.
REQ-028 A stall (ready=0) SHALL freeze all counters, state and data except the pending latch; preemption SHALL wait for the next transfer.
REQ-029 A new request of any priority SHALL be evaluated in the same cycle as an end-of-effect transfer, so no effect is lost.
REQ-030 Latency: with sample_ready=1, a req pulse at cycle t SHALL give state PLAY at t+2 and the first tone sample on sample_data at t+3.

Reset
REQ-031 With reset_n=0 at a clock edge, the block SHALL set: state IDLE, pending=0, phase_cnt=0, dur_cnt=0, polarity +, sample_data=0, sample_valid=0, busy=0, active_id=0.
REQ-032 Reset asserted mid-effect SHALL discard the effect and all pending requests; no tone samples SHALL follow reset release until a new req.
REQ-033 In the first cycle after reset release, sample_valid SHALL be 0; it SHALL be 1 from the second cycle on.

Verification
REQ-034 ready=1, req=001 one cycle -> exactly 4800 nonzero samples (24×+8000 then 24×-8000, repeating), then 0; busy falls after the last one; active_id=0 throughout.
REQ-035 ready=1, req=001, then req=100 1000 cycles later -> score cut after 1000±2 samples; collision plays 24000 samples starting at +8000; score does not resume.
REQ-036 During collision, req=010 -> jump waits; it starts right after sample 24000 with no idle zero between the effects; active_id goes 2 then 1.
REQ-037 ready toggled at random (50%) during jump -> transferred sequence identical to the ready=1 case; sample_data is stable on every stalled cycle.
REQ-038 mute=1 during score -> all samples 0; busy and duration are unchanged (4800 transfers).
REQ-039 reset_n=0 for 1 cycle mid-collision -> all outputs at reset values the next cycle; 0 samples afterwards; pending is empty.

Source files
------------

// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: latches effect requests, plays the highest-priority one as a
// square wave into the audio FIFO, and preempts lower effects on a sample boundary.
module sfx_arbiter #(
    parameter logic signed [15:0] AMP  = 16'sd8000,
    parameter int                 HP0  = 24,
    parameter int                 HP1  = 48,
    parameter int                 HP2  = 120,
    parameter int                 DUR0 = 4800,
    parameter int                 DUR1 = 7200,
    parameter int                 DUR2 = 24000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic        mute,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic [1:0]  active_id
);

    // state | meaning
    // IDLE  | no effect playing, zero samples streamed
    // PLAY  | effect id_q streaming tone samples
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PLAY = 1'b1;

    localparam logic [15:0] HP0_M1  = 16'(HP0 - 1);
    localparam logic [15:0] HP1_M1  = 16'(HP1 - 1);
    localparam logic [15:0] HP2_M1  = 16'(HP2 - 1);
    localparam logic [23:0] DUR0_M1 = 24'(DUR0 - 1);
    localparam logic [23:0] DUR1_M1 = 24'(DUR1 - 1);
    localparam logic [23:0] DUR2_M1 = 24'(DUR2 - 1);
    localparam logic [15:0] AMP_POS = AMP;
    localparam logic [15:0] AMP_NEG = 16'(-AMP);

    logic        state_q, state_d;
    logic [2:0]  pending_q, pending_d;
    logic [1:0]  id_q, id_d;
    logic [15:0] phase_q, phase_d;
    logic [23:0] dur_q, dur_d;
    logic        pol_q, pol_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;

    logic        xfer;
    logic        start;
    logic [2:0]  cand;
    logic [2:0]  start_mask;
    logic [1:0]  pend_hi;
    logic [1:0]  cand_hi;
    logic [15:0] hp_m1;
    logic [23:0] dur_m1;
    logic [15:0] tone;

    function automatic logic [1:0] hi_idx(input logic [2:0] v);
        if (v[2])      return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    always_comb begin
        xfer    = valid_q & sample_ready;
        pend_hi = hi_idx(pending_q);
        case (id_q)
            2'd1:    begin hp_m1 = HP1_M1; dur_m1 = DUR1_M1; end
            2'd2:    begin hp_m1 = HP2_M1; dur_m1 = DUR2_M1; end
            default: begin hp_m1 = HP0_M1; dur_m1 = DUR0_M1; end
        endcase
        tone = mute ? 16'd0 : (pol_q ? AMP_NEG : AMP_POS);

        state_d = state_q;
        id_d    = id_q;
        phase_d = phase_q;
        dur_d   = dur_q;
        pol_d   = pol_q;
        data_d  = data_q;
        valid_d = 1'b1;
        start   = 1'b0;
        cand    = pending_q;

        if (state_q == ST_IDLE) begin
            if (xfer) data_d = 16'd0;
            if (pending_q != 3'd0) start = 1'b1;
        end else if (xfer) begin
            data_d = tone;
            if (dur_q == dur_m1) begin
                // requests arriving on the final sample are honoured immediately
                cand = pending_q | req;
                if (cand != 3'd0) start = 1'b1;
                else              state_d = ST_IDLE;
            end else if (pending_q != 3'd0 && pend_hi > id_q) begin
                start = 1'b1;
            end else begin
                dur_d = dur_q + 24'd1;
                if (phase_q == hp_m1) begin
                    phase_d = 16'd0;
                    pol_d   = ~pol_q;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
        end

        cand_hi    = hi_idx(cand);
        start_mask = start ? (3'b001 << cand_hi) : 3'b000;
        if (start) begin
            state_d = ST_PLAY;
            id_d    = cand_hi;
            phase_d = 16'd0;
            dur_d   = 24'd0;
            pol_d   = 1'b0;
        end

        // a req that is itself the reason for a start is consumed, not re-queued
        pending_d = (pending_q & ~start_mask) | (req & ~(start_mask & ~pending_q));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= 3'd0;
            id_q      <= 2'd0;
            phase_q   <= 16'd0;
            dur_q     <= 24'd0;
            pol_q     <= 1'b0;
            data_q    <= 16'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            phase_q   <= phase_d;
            dur_q     <= dur_d;
            pol_q     <= pol_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q == ST_PLAY);
    assign active_id    = (state_q == ST_PLAY) ? id_q : 2'd0;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter with shortened effects so every sample is checked.
module tb_sfx_arbiter;

    localparam int AMP  = 100;
    localparam int HP0  = 2;
    localparam int HP1  = 3;
    localparam int HP2  = 4;
    localparam int DUR0 = 10;
    localparam int DUR1 = 12;
    localparam int DUR2 = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req;
    logic        mute;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic [1:0]  active_id;

    int checks = 0;
    int errors = 0;

    sfx_arbiter #(
        .AMP(16'sd100), .HP0(HP0), .HP1(HP1), .HP2(HP2),
        .DUR0(DUR0), .DUR1(DUR1), .DUR2(DUR2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .mute(mute),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .active_id(active_id)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] tone(input int k, input int hp);
        return (((k / hp) % 2) == 0) ? 16'(AMP) : 16'(-AMP);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] prev;
        int k;
        int iter;

        reset_n = 1'b0; req = 3'd0; mute = 1'b0; sample_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", sample_valid, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_id", active_id, 0);
        reset_n = 1'b1;
        tick();
        chk("rel_valid", sample_valid, 1);
        chk("rel_data", sample_data, 0);

        // single score effect
        req = 3'b001; tick(); req = 3'b000;
        chk("score_lat_busy0", busy, 0);
        tick();
        chk("score_lat_busy1", busy, 1);
        chk("score_id", active_id, 0);
        for (int i = 0; i < DUR0; i++) begin
            tick();
            chk("score_data", sample_data, tone(i, HP0));
            chk("score_busy", busy, (i < DUR0 - 1) ? 1 : 0);
        end
        tick();
        chk("score_after", sample_data, 0);

        // score preempted by collision, jump queued behind collision
        req = 3'b001; tick(); req = 3'b000; tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pre_score", sample_data, tone(i, HP0));
        end
        req = 3'b100; tick(); req = 3'b000;
        chk("pre_score3", sample_data, tone(3, HP0));
        chk("pre_id0", active_id, 0);
        tick();
        chk("pre_score4", sample_data, tone(4, HP0));
        chk("pre_id2", active_id, 2);
        for (int i = 0; i < DUR2; i++) begin
            if (i == 5) req = 3'b010;
            tick();
            req = 3'b000;
            chk("coll_data", sample_data, tone(i, HP2));
            chk("coll_busy", busy, 1);
            chk("coll_id", active_id, (i < DUR2 - 1) ? 2 : 1);
        end

        // jump under random back-pressure
        prev = tone(DUR2 - 1, HP2);
        k = 0;
        iter = 0;
        while (k < DUR1 && iter < 300) begin
            sample_ready = 1'($urandom_range(0, 1));
            tick();
            iter++;
            if (!sample_ready) begin
                chk("stall_hold", sample_data, prev);
            end else begin
                chk("jump_data", sample_data, tone(k, HP1));
                chk("jump_busy", busy, (k < DUR1 - 1) ? 1 : 0);
                prev = tone(k, HP1);
                k++;
            end
        end
        chk("jump_count", k, DUR1);
        sample_ready = 1'b1;
        tick();
        chk("jump_after", sample_data, 0);
        chk("jump_after_busy", busy, 0);

        // muted score keeps its duration
        mute = 1'b1;
        req = 3'b001; tick(); req = 3'b000; tick();
        for (int i = 0; i < DUR0; i++) begin
            tick();
            chk("mute_data", sample_data, 0);
            chk("mute_busy", busy, (i < DUR0 - 1) ? 1 : 0);
        end
        mute = 1'b0;
        tick();

        // request landing exactly on the last sample starts without a gap
        req = 3'b001; tick(); req = 3'b000; tick();
        for (int i = 0; i < DUR0; i++) begin
            if (i == DUR0 - 1) req = 3'b010;
            tick();
            req = 3'b000;
            chk("eoe_data", sample_data, tone(i, HP0));
        end
        chk("eoe_busy", busy, 1);
        chk("eoe_id", active_id, 1);
        for (int i = 0; i < DUR1; i++) begin
            tick();
            chk("eoe_jump", sample_data, tone(i, HP1));
        end
        chk("eoe_end_busy", busy, 0);
        tick(); tick();
        chk("eoe_no_replay", busy, 0);

        // reset mid-collision with a score pending
        req = 3'b100; tick(); req = 3'b000; tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) req = 3'b001;
            tick();
            req = 3'b000;
            chk("rc_data", sample_data, tone(i, HP2));
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rc_valid", sample_valid, 0);
        chk("rc_data0", sample_data, 0);
        chk("rc_busy", busy, 0);
        chk("rc_id", active_id, 0);
        tick();
        chk("rc_valid1", sample_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rc_quiet_busy", busy, 0);
            chk("rc_quiet_data", sample_data, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
